// File: rtl/alu4_rr_sched_if.sv
// Bundle of the requester, response and shared-ALU signals around alu4_rr_sched.
// The slave modport is the scheduler's view; the master modport is the view of the
// surroundings (two issuing units plus the external alu4 instance).
interface alu4_rr_sched_if #(
    parameter int DATA_W = 4,
    parameter int CTL_W  = 2
);
    logic              req0_valid;
    logic              req0_ready;
    logic [CTL_W-1:0]  req0_ctl;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [CTL_W-1:0]  req1_ctl;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_data;
    logic [2:0]        rsp0_flags;

    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_data;
    logic [2:0]        rsp1_flags;

    logic [CTL_W-1:0]  alu_ctl;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zf;
    logic              alu_cf;
    logic              alu_sf;

    logic              busy;

    modport slave (
        input  req0_valid, req0_ctl, req0_a, req0_b,
        input  req1_valid, req1_ctl, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        input  alu_out, alu_zf, alu_cf, alu_sf,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp0_flags,
        output rsp1_valid, rsp1_data, rsp1_flags,
        output alu_ctl, alu_a, alu_b,
        output busy
    );

    modport master (
        output req0_valid, req0_ctl, req0_a, req0_b,
        output req1_valid, req1_ctl, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        output alu_out, alu_zf, alu_cf, alu_sf,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_flags,
        input  rsp1_valid, rsp1_data, rsp1_flags,
        input  alu_ctl, alu_a, alu_b,
        input  busy
    );
endinterface

// File: rtl/alu4_rr_sched.sv
// Round-robin scheduler sharing one external combinational alu4 between two requesters.
// One op in flight: IDLE accepts, ISSUE holds operands for SETTLE_CYC cycles, RESP
// presents the captured result to the granted requester until it is consumed.
// SETTLE_CYC must lie in 1..15 (cnt is 4 bits).
module alu4_rr_sched #(
    parameter int DATA_W     = 4,
    parameter int CTL_W      = 2,
    parameter int SETTLE_CYC = 1
) (
    input logic            clk,
    input logic            rst_n,
    alu4_rr_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYC - 1);

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              grant_id;
    logic              winner;
    logic              accept;
    logic              settle_done;
    logic              rsp_fire;
    logic [3:0]        cnt;
    logic [CTL_W-1:0]  op_ctl;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] res_data;
    logic [2:0]        res_flags;

    // Arbitration: a lone valid wins; on a tie the requester other than last_grant wins.
    always_comb begin
        // NOTE: defaults first, so every path assigns the signal and no latch is inferred.
        winner = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_grant;
        end else if (bus.req1_valid) begin
            winner = 1'b1;
        end
    end

    assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !winner;
    assign bus.req1_ready = (state == IDLE) && bus.req1_valid &&  winner;
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign settle_done    = (state == ISSUE) && (cnt == LAST_CNT);
    assign rsp_fire       = (state == RESP) && (grant_id ? bus.rsp1_ready : bus.rsp0_ready);

    // Next-state logic; the response handshake returns to IDLE without a same-cycle accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = ISSUE;
            ISSUE:   if (settle_done) state_nxt = RESP;
            RESP:    if (rsp_fire)    state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping, settle counter and operand registers feeding the alu.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand registers are reset because they drive alu_* directly and must read 0.
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            cnt        <= 4'd0;
            op_ctl     <= '0;
            op_a       <= '0;
            op_b       <= '0;
        end else if (accept) begin
            grant_id   <= winner;
            last_grant <= winner;
            cnt        <= 4'd0;
            op_ctl     <= winner ? bus.req1_ctl : bus.req0_ctl;
            op_a       <= winner ? bus.req1_a   : bus.req0_a;
            op_b       <= winner ? bus.req1_b   : bus.req0_b;
        end else if (state == ISSUE) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Capture result and flags once the operands have settled for SETTLE_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data  <= '0;
            res_flags <= 3'b000;
        end else if (settle_done) begin
            res_data  <= bus.alu_out;
            res_flags <= {bus.alu_zf, bus.alu_cf, bus.alu_sf};
        end
    end

    assign bus.alu_ctl    = op_ctl;
    assign bus.alu_a      = op_a;
    assign bus.alu_b      = op_b;
    assign bus.rsp0_valid = (state == RESP) && !grant_id;
    assign bus.rsp1_valid = (state == RESP) &&  grant_id;
    assign bus.rsp0_data  = res_data;
    assign bus.rsp1_data  = res_data;
    assign bus.rsp0_flags = res_flags;
    assign bus.rsp1_flags = res_flags;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_alu4_rr_sched.sv
// Self-checking bench for alu4_rr_sched. Models the external alu4 (0 add, 1 sub,
// 2 and, 3 xor; flags {ZF,CF,SF}) and checks scheduling against round-robin rules,
// response latency and hold behaviour. dut_a uses SETTLE_CYC=1, dut_b SETTLE_CYC=3.
module tb_alu4_rr_sched;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu4_rr_sched_if #(.DATA_W(4), .CTL_W(2)) bus_a ();
    alu4_rr_sched_if #(.DATA_W(4), .CTL_W(2)) bus_b ();

    alu4_rr_sched #(.DATA_W(4), .CTL_W(2), .SETTLE_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    alu4_rr_sched #(.DATA_W(4), .CTL_W(2), .SETTLE_CYC(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    // Reference alu: returns {data[3:0], ZF, CF, SF}.
    function automatic logic [6:0] alu_ref(input logic [1:0] ctl, input logic [3:0] a,
                                           input logic [3:0] b);
        logic [4:0] s;
        case (ctl)
            2'd0:    s = {1'b0, a} + {1'b0, b};
            2'd1:    s = {1'b0, a} - {1'b0, b};
            2'd2:    s = {1'b0, a & b};
            default: s = {1'b0, a ^ b};
        endcase
        return {s[3:0], (s[3:0] == 4'd0), s[4], s[3]};
    endfunction

    assign {bus_a.alu_out, bus_a.alu_zf, bus_a.alu_cf, bus_a.alu_sf} =
        alu_ref(bus_a.alu_ctl, bus_a.alu_a, bus_a.alu_b);
    assign {bus_b.alu_out, bus_b.alu_zf, bus_b.alu_cf, bus_b.alu_sf} =
        alu_ref(bus_b.alu_ctl, bus_b.alu_a, bus_b.alu_b);

    logic [28:0] outs_a;
    assign outs_a = {bus_a.req0_ready, bus_a.req1_ready, bus_a.rsp0_valid, bus_a.rsp1_valid,
                     bus_a.rsp0_data, bus_a.rsp0_flags, bus_a.rsp1_data, bus_a.rsp1_flags,
                     bus_a.alu_ctl, bus_a.alu_a, bus_a.alu_b, bus_a.busy};

    task automatic idle_inputs();
        bus_a.req0_valid = 0; bus_a.req0_ctl = 0; bus_a.req0_a = 0; bus_a.req0_b = 0;
        bus_a.req1_valid = 0; bus_a.req1_ctl = 0; bus_a.req1_a = 0; bus_a.req1_b = 0;
        bus_a.rsp0_ready = 0; bus_a.rsp1_ready = 0;
        bus_b.req0_valid = 0; bus_b.req0_ctl = 0; bus_b.req0_a = 0; bus_b.req0_b = 0;
        bus_b.req1_valid = 0; bus_b.req1_ctl = 0; bus_b.req1_a = 0; bus_b.req1_b = 0;
        bus_b.rsp0_ready = 0; bus_b.rsp1_ready = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    // Waits (bounded) on negedges for the selected dut_a response; lat=-1 on timeout.
    task automatic wait_rsp_a(input bit id, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if ((id ? bus_a.rsp1_valid : bus_a.rsp0_valid) === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        @(negedge clk); #1;
        vectors++;
        if (outs_a !== '0) begin
            miscompares++; $display("FAIL reset_outputs_held: got %h expected 0", outs_a);
        end
        @(negedge clk);
        rst_n = 1; #1;
        vectors++;
        if (outs_a !== '0) begin
            miscompares++; $display("FAIL reset_outputs_released: got %h expected 0", outs_a);
        end
        bus_a.req0_valid = 1; bus_a.req0_ctl = 0; bus_a.req0_a = 3; bus_a.req0_b = 12;
        bus_a.rsp0_ready = 1;
        #1;
        vectors++;
        if (bus_a.req0_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_first_ready: got %b expected 1", bus_a.req0_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus_a.req0_valid = 0;
        vectors++;
        if (bus_a.busy !== 1'b1 || bus_a.rsp0_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_issue: got busy=%b rsp0_valid=%b expected 1/0",
                     bus_a.busy, bus_a.rsp0_valid);
        end
        @(negedge clk);
        vectors++;
        if ({bus_a.rsp0_valid, bus_a.rsp0_data, bus_a.rsp0_flags} !== {1'b1, 4'd15, 3'b001}) begin
            miscompares++;
            $display("FAIL reset_add_rsp: got v=%b d=%0d f=%b expected v=1 d=15 f=001",
                     bus_a.rsp0_valid, bus_a.rsp0_data, bus_a.rsp0_flags);
        end
        @(negedge clk);
        vectors++;
        if (bus_a.busy !== 1'b0 || bus_a.rsp0_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_return_idle: got busy=%b rsp0_valid=%b expected 0/0",
                     bus_a.busy, bus_a.rsp0_valid);
        end
    endtask

    task automatic test_contention();
        int lat;
        apply_reset();
        bus_a.rsp0_ready = 1; bus_a.rsp1_ready = 1;
        bus_a.req0_valid = 1; bus_a.req0_ctl = 1; bus_a.req0_a = 9; bus_a.req0_b = 4;
        bus_a.req1_valid = 1; bus_a.req1_ctl = 3; bus_a.req1_a = 5; bus_a.req1_b = 6;
        #1;
        vectors++;
        if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b10) begin
            miscompares++; $display("FAIL contention_first: got %b%b expected 10",
                                    bus_a.req0_ready, bus_a.req1_ready);
        end
        @(posedge clk); @(negedge clk);
        bus_a.req0_valid = 0;
        wait_rsp_a(1'b0, lat);
        vectors++;
        if (lat !== 1 || bus_a.rsp0_data !== 4'd5) begin
            miscompares++; $display("FAIL contention_rsp0: got lat=%0d d=%0d expected 1/5",
                                    lat, bus_a.rsp0_data);
        end
        @(negedge clk); #1;
        vectors++;
        if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b01) begin
            miscompares++; $display("FAIL contention_second: got %b%b expected 01",
                                    bus_a.req0_ready, bus_a.req1_ready);
        end
        @(posedge clk); @(negedge clk);
        bus_a.req1_valid = 0;
        wait_rsp_a(1'b1, lat);
        vectors++;
        if (lat !== 1 || bus_a.rsp1_data !== 4'd3 || bus_a.rsp0_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL contention_rsp1: got lat=%0d d=%0d rsp0_valid=%b expected 1/3/0",
                     lat, bus_a.rsp1_data, bus_a.rsp0_valid);
        end
        @(negedge clk);
        bus_a.req0_valid = 1; bus_a.req1_valid = 1;
        #1;
        vectors++;
        if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b10) begin
            miscompares++; $display("FAIL contention_third: got %b%b expected 10",
                                    bus_a.req0_ready, bus_a.req1_ready);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int lat;
        apply_reset();
        bus_a.req1_valid = 1; bus_a.req1_ctl = 2; bus_a.req1_a = 13; bus_a.req1_b = 7;
        @(posedge clk); @(negedge clk);
        bus_a.req1_valid = 0;
        bus_a.req0_valid = 1; bus_a.req0_ctl = 0; bus_a.req0_a = 2; bus_a.req0_b = 2;
        bus_a.rsp0_ready = 1;
        wait_rsp_a(1'b1, lat);
        vectors++;
        if (lat !== 1) begin
            miscompares++; $display("FAIL bp_latency: got %0d expected 1", lat);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if ({bus_a.rsp1_valid, bus_a.rsp1_data, bus_a.rsp1_flags, bus_a.req0_ready} !==
                {1'b1, 4'd5, 3'b000, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%0d f=%b r0=%b expected 1/5/000/0", i,
                         bus_a.rsp1_valid, bus_a.rsp1_data, bus_a.rsp1_flags, bus_a.req0_ready);
            end
            @(negedge clk);
        end
        bus_a.rsp1_ready = 1;
        #1;
        vectors++;
        if (bus_a.req0_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_no_same_cycle: got %b expected 0", bus_a.req0_ready);
        end
        @(posedge clk); @(negedge clk); #1;
        vectors++;
        if (bus_a.req0_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_accept_next: got %b expected 1", bus_a.req0_ready);
        end
        @(posedge clk); @(negedge clk);
        bus_a.req0_valid = 0; bus_a.rsp1_ready = 0;
        wait_rsp_a(1'b0, lat);
        vectors++;
        if (lat !== 1 || bus_a.rsp0_data !== 4'd4) begin
            miscompares++; $display("FAIL bp_req0_rsp: got lat=%0d d=%0d expected 1/4",
                                    lat, bus_a.rsp0_data);
        end
        idle_inputs();
    endtask

    task automatic test_settle();
        int lat;
        apply_reset();
        bus_b.req0_valid = 1; bus_b.req0_ctl = 0; bus_b.req0_a = 8; bus_b.req0_b = 8;
        bus_b.rsp0_ready = 1;
        @(posedge clk); @(negedge clk);
        bus_b.req0_valid = 0; bus_b.req0_a = 1; bus_b.req0_b = 2;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (bus_b.alu_a !== 4'd8 || bus_b.alu_b !== 4'd8) begin
                miscompares++; $display("FAIL settle_operands[%0d]: got a=%0d b=%0d expected 8/8",
                                        i, bus_b.alu_a, bus_b.alu_b);
            end
            if (bus_b.rsp0_valid === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (lat !== 3) begin
            miscompares++; $display("FAIL settle_latency: got %0d expected 3", lat);
        end
        vectors++;
        if (bus_b.rsp0_data !== 4'd0 || bus_b.rsp0_flags !== 3'b110) begin
            miscompares++; $display("FAIL settle_rsp: got d=%0d f=%b expected 0/110",
                                    bus_b.rsp0_data, bus_b.rsp0_flags);
        end
        @(negedge clk);
        vectors++;
        if (bus_b.busy !== 1'b0) begin
            miscompares++; $display("FAIL settle_idle: got busy=%b expected 0", bus_b.busy);
        end
        idle_inputs();
    endtask

    task automatic test_abort();
        int lat;
        apply_reset();
        bus_a.rsp0_ready = 1;
        bus_a.req0_valid = 1; bus_a.req0_ctl = 0; bus_a.req0_a = 1; bus_a.req0_b = 2;
        @(posedge clk); @(negedge clk);
        bus_a.req0_valid = 0;
        vectors++;
        if (bus_a.busy !== 1'b1) begin
            miscompares++; $display("FAIL abort_in_issue: got busy=%b expected 1", bus_a.busy);
        end
        rst_n = 0; #1;
        vectors++;
        if (outs_a !== '0) begin
            miscompares++; $display("FAIL abort_outputs: got %h expected 0", outs_a);
        end
        #1 rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus_a.rsp0_valid, bus_a.rsp1_valid, bus_a.busy} !== 3'b000) begin
                miscompares++; $display("FAIL abort_no_rsp[%0d]: got %b expected 000", i,
                                        {bus_a.rsp0_valid, bus_a.rsp1_valid, bus_a.busy});
            end
        end
        bus_a.req0_valid = 1; bus_a.req0_ctl = 1; bus_a.req0_a = 7; bus_a.req0_b = 3;
        @(posedge clk); @(negedge clk);
        bus_a.req0_valid = 0;
        wait_rsp_a(1'b0, lat);
        vectors++;
        if (lat !== 1 || bus_a.rsp0_data !== 4'd4 || bus_a.rsp0_flags !== 3'b000) begin
            miscompares++; $display("FAIL abort_recover: got lat=%0d d=%0d f=%b expected 1/4/000",
                                    lat, bus_a.rsp0_data, bus_a.rsp0_flags);
        end
        idle_inputs();
    endtask

    task automatic test_valid_drop();
        int lat;
        apply_reset();
        bus_a.req0_valid = 1; bus_a.req0_ctl = 0; bus_a.req0_a = 6; bus_a.req0_b = 1;
        @(posedge clk); @(negedge clk);
        bus_a.req0_valid = 0;
        wait_rsp_a(1'b0, lat);
        bus_a.req1_valid = 1; bus_a.req1_ctl = 3; bus_a.req1_a = 15; bus_a.req1_b = 15;
        #1;
        vectors++;
        if (lat !== 1 || bus_a.req1_ready !== 1'b0) begin
            miscompares++; $display("FAIL drop_while_busy: got lat=%0d r1=%b expected 1/0",
                                    lat, bus_a.req1_ready);
        end
        @(negedge clk);
        bus_a.req1_valid = 0; bus_a.rsp0_ready = 1;
        @(negedge clk);
        bus_a.rsp0_ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bus_a.busy !== 1'b0 || bus_a.alu_a !== 4'd6 || bus_a.rsp1_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL drop_no_issue[%0d]: got busy=%b alu_a=%0d rsp1_valid=%b expected 0/6/0",
                         i, bus_a.busy, bus_a.alu_a, bus_a.rsp1_valid);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        bit         model_last;
        bit         w;
        logic [1:0] v;
        logic [1:0] c0, c1;
        logic [3:0] a0, b0, a1, b1;
        logic [6:0] ex;
        int         lat, hold;
        apply_reset();
        model_last = 1'b1;
        for (int t = 0; t < 40; t++) begin
            v  = 2'($urandom_range(1, 3));
            c0 = 2'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
            c1 = 2'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
            bus_a.req0_valid = v[0]; bus_a.req0_ctl = c0; bus_a.req0_a = a0; bus_a.req0_b = b0;
            bus_a.req1_valid = v[1]; bus_a.req1_ctl = c1; bus_a.req1_a = a1; bus_a.req1_b = b1;
            w  = (v == 2'b11) ? ~model_last : v[1];
            ex = w ? alu_ref(c1, a1, b1) : alu_ref(c0, a0, b0);
            #1;
            vectors++;
            if ({bus_a.req0_ready, bus_a.req1_ready} !== {!w, w}) begin
                miscompares++; $display("FAIL rand_grant[%0d]: got %b%b expected %b%b", t,
                                        bus_a.req0_ready, bus_a.req1_ready, !w, w);
            end
            @(posedge clk); @(negedge clk);
            bus_a.req0_valid = 0; bus_a.req1_valid = 0;
            model_last = w;
            wait_rsp_a(w, lat);
            vectors++;
            if (lat !== 1) begin
                miscompares++; $display("FAIL rand_latency[%0d]: got %0d expected 1", t, lat);
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h <= hold; h++) begin
                vectors++;
                if ((w ? {bus_a.rsp1_valid, bus_a.rsp0_valid, bus_a.rsp1_data, bus_a.rsp1_flags}
                       : {bus_a.rsp0_valid, bus_a.rsp1_valid, bus_a.rsp0_data, bus_a.rsp0_flags})
                    !== {1'b1, 1'b0, ex}) begin
                    miscompares++;
                    $display("FAIL rand_rsp[%0d]: got d0=%h f0=%b d1=%h f1=%b v=%b%b expected %h",
                             t, bus_a.rsp0_data, bus_a.rsp0_flags, bus_a.rsp1_data,
                             bus_a.rsp1_flags, bus_a.rsp0_valid, bus_a.rsp1_valid, ex);
                end
                if (h == hold) begin
                    if (w) bus_a.rsp1_ready = 1; else bus_a.rsp0_ready = 1;
                end
                @(negedge clk);
            end
            bus_a.rsp0_ready = 0; bus_a.rsp1_ready = 0;
            vectors++;
            if (bus_a.busy !== 1'b0) begin
                miscompares++; $display("FAIL rand_idle[%0d]: got busy=%b expected 0", t, bus_a.busy);
            end
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_contention();
        test_backpressure();
        test_settle();
        test_abort();
        test_valid_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
